// File: rtl/periph_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | periph_bus_pkg : shared types and defaults for the peripheral decoder    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RV  = 2'd2,
    ERR_RSP  = 2'd3
  } state_e;

  localparam int          DEF_NSLV   = 4;
  localparam logic [31:0] DEF_BASE   = 32'h1000_0000;
  localparam int          DEF_SLV_AW = 8;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

endpackage
`default_nettype wire

// File: rtl/pbd_timeout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pbd_timeout : access-age counter, expire flags the last allowed cycle    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pbd_timeout
  import periph_bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear loads 1: the request cycle itself is the first cycle of the access.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CW'(1);
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/periph_bus_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | periph_bus_decoder : one master to NSLV slave decoder with error/timeout |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module periph_bus_decoder
  import periph_bus_pkg::*;
#(
  parameter int          NSLV    = DEF_NSLV,
  parameter logic [31:0] BASE    = DEF_BASE,
  parameter int          SLV_AW  = DEF_SLV_AW,
  parameter int          TIMEOUT = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               m_req,
  input  logic               m_we,
  input  logic [3:0]         m_be,
  input  logic [31:0]        m_addr,
  input  logic [31:0]        m_wdata,
  output logic               m_gnt,
  output logic               m_rvalid,
  output logic               m_err,
  output logic [31:0]        m_rdata,
  output logic [NSLV-1:0]    s_req,
  output logic               s_we,
  output logic [3:0]         s_be,
  output logic [31:0]        s_addr,
  output logic [31:0]        s_wdata,
  input  logic [NSLV-1:0]    s_gnt,
  input  logic [NSLV-1:0]    s_rvalid,
  input  logic [NSLV-1:0]    s_err,
  input  logic [NSLV*32-1:0] s_rdata,
  output logic [15:0]        err_cnt
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  logic [31:0]     off, win;
  logic            hit;
  logic [SW-1:0]   sel;

  state_e          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d, cur_sel;
  rsp_t            rsp_q, rsp_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic [NSLV-1:0] req_oh;
  logic            gnt_c, cap, fail, err_inc;
  logic            tmo_clr, tmo_en, tmo_exp;

  always_comb begin
    off = m_addr - BASE;
    win = off >> SLV_AW;
    hit = (m_addr >= BASE) && (win < 32'(NSLV));
    sel = win[SW-1:0];
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cur_sel = sel_q;
    req_oh  = '0;
    gnt_c   = 1'b0;
    cap     = 1'b0;
    fail    = 1'b0;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    case (state_q)
      // ERR_RSP is the cycle the error response is on the bus; it already takes the next access.
      IDLE, ERR_RSP: begin
        state_d = IDLE;
        if (m_req && !hit) begin
          gnt_c   = 1'b1;
          fail    = 1'b1;
        end else if (m_req) begin
          cur_sel     = sel;
          sel_d       = sel;
          tmo_clr     = 1'b1;
          req_oh[sel] = 1'b1;
          if (s_gnt[sel]) begin
            gnt_c = 1'b1;
            if (s_rvalid[sel]) cap = 1'b1;
            else               state_d = WAIT_RV;
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        tmo_en        = 1'b1;
        req_oh[sel_q] = 1'b1;
        if (s_gnt[sel_q] && s_rvalid[sel_q]) begin
          gnt_c   = 1'b1;
          cap     = 1'b1;
          state_d = IDLE;
        end else if (tmo_exp) begin
          req_oh = '0;
          gnt_c  = 1'b1;
          fail   = 1'b1;
        end else if (s_gnt[sel_q]) begin
          gnt_c   = 1'b1;
          state_d = WAIT_RV;
        end
      end
      WAIT_RV: begin
        tmo_en = 1'b1;
        if (s_rvalid[sel_q]) begin
          cap     = 1'b1;
          state_d = IDLE;
        end else if (tmo_exp) begin
          fail = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rsp_d   = '0;
    err_inc = 1'b0;
    if (fail) begin
      state_d    = ERR_RSP;
      rsp_d.rvalid = 1'b1;
      rsp_d.err    = 1'b1;
      err_inc      = 1'b1;
    end else if (cap) begin
      rsp_d.rvalid = 1'b1;
      rsp_d.err    = s_err[cur_sel];
      rsp_d.rdata  = s_rdata[{cur_sel, 5'b0} +: 32];
      err_inc      = s_err[cur_sel];
    end

    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rsp_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rsp_q     <= rsp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  pbd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_exp)
  );

  // Request side is combinational from state, so it must be forced quiet while in reset.
  assign s_req    = Rst ? '0 : req_oh;
  assign m_gnt    = !Rst && gnt_c;
  assign m_rvalid = rsp_q.rvalid;
  assign m_err    = rsp_q.err;
  assign m_rdata  = rsp_q.rdata;
  assign err_cnt  = err_cnt_q;
  assign s_we     = m_we;
  assign s_be     = m_be;
  assign s_addr   = m_addr;
  assign s_wdata  = m_wdata;

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_periph_bus_decoder : directed + random bench with access-level model  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_periph_bus_decoder;

  localparam int          NSLV    = 4;
  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam int          SLV_AW  = 8;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] END_A   = BASE + 32'(NSLV << SLV_AW);

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic m_req = 1'b0, m_we = 1'b0;
  logic [3:0] m_be = '0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic m_gnt, m_rvalid, m_err;
  logic [31:0] m_rdata;
  logic [NSLV-1:0] s_req;
  logic s_we;
  logic [3:0] s_be;
  logic [31:0] s_addr, s_wdata;
  logic [NSLV-1:0] s_gnt = '0, s_rvalid = '0, s_err = '0;
  logic [NSLV*32-1:0] s_rdata = '0;
  logic [15:0] err_cnt;

  periph_bus_decoder #(.NSLV(NSLV), .BASE(BASE), .SLV_AW(SLV_AW), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata), .err_cnt(err_cnt)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Access-level model: one outstanding access described by target, age and grant status.
  bit          busy = 0, granted = 0;
  int          msel = 0, age = 0;
  bit          e_rv = 0, e_err = 0;
  logic [31:0] e_rdata = '0;
  int          e_cnt = 0;
  logic [NSLV-1:0] x_req;
  bit          x_gnt;

  logic [NSLV-1:0] smp_req;
  logic        smp_gnt, smp_rv, smp_err;
  logic [31:0] smp_rdata;
  logic [15:0] smp_cnt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit done, fail, n_rv, n_err;
    logic [31:0] n_rd;
    longint a;
    @(negedge Clk);
    smp_req = s_req; smp_gnt = m_gnt; smp_rv = m_rvalid; smp_err = m_err;
    smp_rdata = m_rdata; smp_cnt = err_cnt;
    done = 0; fail = 0; n_rv = 0; n_err = 0; n_rd = '0;
    x_req = '0; x_gnt = 0;
    if (Rst) begin
      busy = 0;
    end else begin
      if (!busy && m_req) begin
        a = longint'(m_addr) - longint'(BASE);
        if (a >= 0 && a < longint'(NSLV * (1 << SLV_AW))) begin
          msel = int'(a >> SLV_AW); busy = 1; granted = 0; age = 0;
        end else begin
          x_gnt = 1; fail = 1;
        end
      end
      if (busy) begin
        if (!granted) begin
          if (s_gnt[msel] && s_rvalid[msel]) begin
            x_gnt = 1; x_req = NSLV'(1 << msel); done = 1;
          end else if (age == TIMEOUT - 1) begin
            x_gnt = 1; fail = 1;
          end else begin
            x_req = NSLV'(1 << msel);
            if (s_gnt[msel]) begin x_gnt = 1; granted = 1; end
          end
        end else begin
          if (s_rvalid[msel]) done = 1;
          else if (age == TIMEOUT - 1) fail = 1;
        end
        age++;
        if (done || fail) busy = 0;
      end
      if (done) begin
        n_rv = 1; n_err = s_err[msel]; n_rd = s_rdata[msel*32 +: 32];
      end else if (fail) begin
        n_rv = 1; n_err = 1;
      end
    end
    chk("s_req", smp_req, x_req);
    chk("m_gnt", smp_gnt, x_gnt);
    chk("m_rvalid", smp_rv, e_rv);
    chk("m_err", smp_err, e_err);
    chk("m_rdata", smp_rdata, e_rdata);
    chk("err_cnt", smp_cnt, e_cnt);
    chk("mirror_addr", s_addr, m_addr);
    chk("mirror_ctl", {s_we, s_be, s_wdata}, {m_we, m_be, m_wdata});
    if (Rst) begin
      e_rv = 0; e_err = 0; e_rdata = '0; e_cnt = 0;
    end else begin
      e_rv = n_rv; e_err = n_err; e_rdata = n_rd;
      if (n_err && e_cnt < 65535) e_cnt++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    m_req = 0; s_gnt = '0; s_rvalid = '0; s_err = '0;
  endtask

  task automatic rd(input logic [31:0] addr);
    m_req = 1; m_we = 0; m_be = 4'hF; m_addr = addr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcyc;
    bit hold, slow;
    @(posedge Clk); #1;
    step(); step();
    chk("rst_rv", smp_rv, 0);
    chk("rst_cnt", smp_cnt, 0);
    Rst = 0;

    // zero-wait read of slave 0
    rd(32'h1000_0004); s_gnt = 4'b0001; s_rvalid = 4'b0001; s_rdata[31:0] = 32'hDEAD_BEEF;
    step();
    chk("t1_sreq", smp_req, 4'b0001);
    idle_in(); step();
    chk("t1_rdata", smp_rdata, 32'hDEAD_BEEF);
    chk("t1_rv", smp_rv, 1);

    // write to slave 2 with 3-cycle grant delay
    m_req = 1; m_we = 1; m_be = 4'b0011; m_addr = 32'h1000_0210; m_wdata = 32'h1234_5678;
    repeat (3) begin step(); chk("t2_sreq_wait", smp_req, 4'b0100); end
    s_gnt = 4'b0100; step();
    chk("t2_gnt", smp_gnt, 1);
    idle_in(); s_rvalid = 4'b0100; s_rdata[95:64] = 32'h0BAD_F00D; step();
    idle_in(); step();
    chk("t2_rv", smp_rv, 1);

    // unmapped access
    rd(32'h2000_0000); step();
    chk("t3_gnt", smp_gnt, 1);
    chk("t3_sreq", smp_req, 0);
    idle_in(); step();
    chk("t3_err", {smp_rv, smp_err}, 2'b11);
    chk("t3_cnt", smp_cnt, 1);

    // slave 1 never grants
    rd(32'h1000_0100); gcyc = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (smp_gnt) begin gcyc = i; break; end
    end
    chk("t4_gnt_cycle", gcyc, TIMEOUT - 1);
    idle_in(); step();
    chk("t4_err", {smp_rv, smp_err}, 2'b11);
    chk("t4_cnt", smp_cnt, 2);
    repeat (3) step();
    s_rvalid = 4'b0010; step();
    idle_in(); step();
    chk("t4_late_rv", smp_rv, 0);

    // back-to-back reads to slaves 0 and 3
    rd(32'h1000_0000); s_gnt = 4'b0001; s_rvalid = 4'b0001; s_rdata[31:0] = 32'h1111_1111;
    step();
    rd(32'h1000_0300); s_gnt = 4'b1000; s_rvalid = 4'b1000; s_rdata[127:96] = 32'h3333_3333;
    step();
    chk("t5_rd0", smp_rdata, 32'h1111_1111);
    idle_in(); step();
    chk("t5_rd3", {smp_rv, smp_rdata}, {1'b1, 32'h3333_3333});

    // reset while waiting for the response
    rd(32'h1000_0200); s_gnt = 4'b0100; step();
    idle_in(); Rst = 1; step();
    chk("t6_rst_comb", {smp_req, smp_gnt}, 0);
    Rst = 0; s_rvalid = 4'b0100; step();
    chk("t6_rst_out", {smp_rv, smp_err, smp_cnt}, 0);
    idle_in(); step();
    chk("t6_spurious", smp_rv, 0);
    rd(32'h1000_0304); s_gnt = 4'b1000; s_rvalid = 4'b1000; s_rdata[127:96] = 32'h5A5A_5A5A;
    step();
    idle_in(); step();
    chk("t6_fresh", {smp_rv, smp_rdata}, {1'b1, 32'h5A5A_5A5A});

    // randomized traffic
    hold = 0; slow = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) slow = ($urandom_range(0, 1) == 1);
      Rst = ($urandom_range(0, 299) == 0);
      if (!hold) begin
        m_req = ($urandom_range(0, 3) != 0);
        m_we = 1'($urandom); m_be = 4'($urandom); m_wdata = $urandom;
        case ($urandom_range(0, 9))
          0: m_addr = $urandom;
          1: m_addr = BASE - 32'd4;
          2: m_addr = END_A;
          3: m_addr = END_A - 32'd4;
          default: m_addr = BASE + (32'($urandom_range(0, NSLV - 1)) << SLV_AW) + ($urandom & 32'hFC);
        endcase
      end
      for (int k = 0; k < NSLV; k++) begin
        s_gnt[k]    = ($urandom_range(0, slow ? 15 : 1) == 0);
        s_rvalid[k] = ($urandom_range(0, slow ? 15 : 1) == 0);
        s_err[k]    = ($urandom_range(0, 7) == 0);
      end
      s_rdata = {$urandom, $urandom, $urandom, $urandom};
      step();
      hold = m_req && !x_gnt && !Rst;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
